// File: rtl/pb_irq_pkg.sv
// Shared definitions for the PicoBlaze interrupt controller: register map, FSM states
// and the fixed-priority helper used to build the VECTOR register.
package pb_irq_pkg;

  localparam logic [1:0] REG_PENDING  = 2'd0;
  localparam logic [1:0] REG_MASK     = 2'd1;
  localparam logic [1:0] REG_VECTOR   = 2'd2;
  localparam logic [1:0] REG_EDGE_EOI = 2'd3;

  localparam int VEC_VALID_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Lowest set index wins; index 0 is the highest priority.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pb_irq_sync.sv
// One interrupt source: 2-FF synchronizer plus rising-edge pulse; level valid 2 clk after
// the input changes, rise is a single-cycle pulse alongside it. No backpressure.
module pb_irq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= src_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/pb_irq_ctrl.sv
// PicoBlaze interrupt controller: sync'd sources -> PENDING (3 clk) -> fixed-priority FSM driving
// interrupt/interrupt_ack; I/O-port register file with 1-cycle registered read, writes never stall.
module pb_irq_ctrl
  import pb_irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [7:0]  BASE_PORT = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic [7:0]         out_port,
  input  logic               read_strobe,
  output logic [7:0]         rd_data,
  output logic               rd_hit,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  logic [7:0] src_level;
  logic [7:0] src_rise;

  // Unimplemented source slots are tied off so the register file is always 8 bits wide.
  for (genvar g = 0; g < 8; g++) begin : g_src
    if (g < NUM_SRC) begin : g_on
      pb_irq_sync u_sync (
        .clk_i   (clk),
        .rst_ni  (reset),
        .src_i   (irq_src[g]),
        .level_o (src_level[g]),
        .rise_o  (src_rise[g])
      );
    end else begin : g_off
      assign src_level[g] = 1'b0;
      assign src_rise[g]  = 1'b0;
    end
  end

  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q,    mask_d;
  logic [7:0] edge_q,    edge_d;
  logic [7:0] vector_q,  vector_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_hit_q;
  logic       irq_q;
  state_e     state_q;

  logic       port_hit;
  logic [1:0] port_off;
  logic       wr_en;
  logic       wr_pending;
  logic       wr_mask;
  logic       eoi;
  logic [7:0] set_vec;
  logic [7:0] masked;
  logic       active;

  assign port_hit   = (port_id[7:2] == BASE_PORT[7:2]);
  assign port_off   = port_id[1:0];
  assign wr_en      = write_strobe & port_hit;
  assign wr_pending = wr_en & (port_off == REG_PENDING);
  assign wr_mask    = wr_en & (port_off == REG_MASK);
  assign eoi        = wr_en & (port_off == REG_EDGE_EOI);

  assign set_vec = ((edge_q & src_rise) | (~edge_q & src_level)) & SRC_MASK;
  assign masked  = pending_q & mask_q;
  assign active  = |masked;

  // Set is OR'ed in after the W1C so a same-cycle request is never lost.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    edge_d    = edge_q;
    if (wr_pending) pending_d = pending_q & ~out_port;
    pending_d = (pending_d | set_vec) & SRC_MASK;
    if (wr_mask) mask_d = out_port & SRC_MASK;
    if (eoi)     edge_d = out_port & SRC_MASK;
  end

  always_comb begin
    vector_d = 8'h00;
    if (active) begin
      vector_d[VEC_VALID_BIT] = 1'b1;
      vector_d[2:0]           = lowest_idx(masked);
    end
  end

  always_comb begin
    rd_data_d = 8'h00;
    if (port_hit) begin
      case (port_off)
        REG_PENDING:  rd_data_d = pending_q;
        REG_MASK:     rd_data_d = mask_q;
        REG_VECTOR:   rd_data_d = vector_q;
        REG_EDGE_EOI: rd_data_d = edge_q;
        default:      rd_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 8'h00;
      mask_q    <= 8'h00;
      edge_q    <= 8'h00;
      rd_data_q <= 8'h00;
      rd_hit_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= port_hit;
    end
  end

  // interrupt is held through ASSERT regardless of active; VECTOR is decided at the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      vector_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (active) begin
            state_q <= ST_ASSERT;
            irq_q   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (interrupt_ack) begin
            state_q  <= ST_SERVICE;
            irq_q    <= 1'b0;
            vector_q <= vector_d;
          end
        end
        ST_SERVICE: begin
          if (eoi) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_hit    = rd_hit_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Directed bench for pb_irq_ctrl: reset, basic flow, priority, spurious ack, set/clear race, reset mid-ASSERT.
module tb_pb_irq_ctrl;

  localparam logic [7:0] BASE = 8'hF0;

  logic       clk;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic       interrupt;
  logic       interrupt_ack;

  int errors = 0;
  int checks = 0;

  pb_irq_ctrl #(.NUM_SRC(8), .BASE_PORT(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .rd_data       (rd_data),
    .rd_hit        (rd_hit),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] d);
    port_id      = BASE | {6'd0, off};
    out_port     = d;
    write_strobe = 1'b1;
    step(1);
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [7:0] d, output logic h);
    port_id     = BASE | {6'd0, off};
    read_strobe = 1'b1;
    step(1);
    d           = rd_data;
    h           = rd_hit;
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_src = v;
    step(2);
    irq_src = 8'h00;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!interrupt && n < 20) begin
      step(1);
      n++;
    end
  endtask

  task automatic do_ack();
    interrupt_ack = 1'b1;
    step(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       h;
    reset   = 1'b0;
    irq_src = 8'hFF;
    port_id = BASE;
    step(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", interrupt); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
    checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL rst_rd_hit: got %b want 0", rd_hit); end
    reset = 1'b1;
    step(4);
    rd_reg(2'd1, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mask: got %h want 00", d); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL rd_hit_in_range: got %b want 1", h); end
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rst_level_pending: got %h want ff", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_masked_irq: got %b want 0", interrupt); end
    port_id = 8'h10;
    step(1);
    checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL rd_hit_out_of_range: got %b want 0", rd_hit); end
    port_id = 8'h00;
    irq_src = 8'h00;
    step(4);
    wr_reg(2'd0, 8'hFF);
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_w1c_all: got %h want 00", d); end
  endtask

  task automatic test_ack_idle();
    logic [7:0] d;
    logic       h;
    do_ack();
    wr_reg(2'd2, 8'hFF);
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ack_idle_vector: got %h want 00", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_idle_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       h;
    int         n;
    wr_reg(2'd3, 8'hFF);
    wr_reg(2'd1, 8'h04);
    irq_src = 8'h04;
    n = 0;
    while (!interrupt && n < 10) begin
      step(1);
      n++;
      if (n == 2) irq_src = 8'h00;
    end
    irq_src = 8'h00;
    checks++; if (interrupt !== 1'b1 || n < 3 || n > 4) begin errors++; $display("FAIL basic_latency: got irq=%b after %0d cycles want irq=1 after 3..4", interrupt, n); end
    step(2);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_hold: got %b want 1", interrupt); end
    do_ack();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_drop_on_ack: got %b want 0", interrupt); end
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h82) begin errors++; $display("FAIL basic_vector: got %h want 82", d); end
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL basic_no_autoclear: got %h want 04", d); end
    wr_reg(2'd0, 8'h04);
    wr_reg(2'd3, 8'hFF);
    step(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_after_eoi: got %b want 0", interrupt); end
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_pending_clear: got %h want 00", d); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    logic       h;
    int         n;
    wr_reg(2'd1, 8'hFF);
    pulse(8'h22);
    wait_irq(n);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_irq1: got %b want 1 (waited %0d)", interrupt, n); end
    do_ack();
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL prio_vector1: got %h want 81", d); end
    wr_reg(2'd0, 8'h02);
    wr_reg(2'd3, 8'hFF);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_gap: got %b want 0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_reassert: got %b want 1", interrupt); end
    do_ack();
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h85) begin errors++; $display("FAIL prio_vector2: got %h want 85", d); end
    wr_reg(2'd0, 8'h20);
    wr_reg(2'd3, 8'hFF);
    step(2);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", interrupt); end
  endtask

  task automatic test_spurious();
    logic [7:0] d;
    logic       h;
    int         n;
    pulse(8'h40);
    wait_irq(n);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL spur_irq: got %b want 1 (waited %0d)", interrupt, n); end
    wr_reg(2'd1, 8'h00);
    step(2);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL spur_hold: got %b want 1", interrupt); end
    do_ack();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL spur_drop: got %b want 0", interrupt); end
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL spur_vector: got %h want 00", d); end
    wr_reg(2'd1, 8'h40);
    step(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL spur_in_service: got %b want 0", interrupt); end
    wr_reg(2'd3, 8'hFF);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL spur_eoi_gap: got %b want 0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL spur_reassert: got %b want 1", interrupt); end
    do_ack();
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h86) begin errors++; $display("FAIL spur_vector2: got %h want 86", d); end
    wr_reg(2'd0, 8'h40);
    wr_reg(2'd3, 8'hFF);
    step(2);
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    logic       h;
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd3, 8'hFF);
    irq_src = 8'h08;
    step(2);
    wr_reg(2'd0, 8'h08);
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL race_set_wins: got %h want 08", d); end
    wr_reg(2'd0, 8'h08);
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL race_w1c_edge: got %h want 00", d); end
    wr_reg(2'd3, 8'h00);
    step(1);
    rd_reg(2'd3, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_readback: got %h want 00", d); end
    wr_reg(2'd0, 8'h08);
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL level_repend: got %h want 08", d); end
    irq_src = 8'h00;
    step(4);
    wr_reg(2'd0, 8'h08);
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL level_cleared: got %h want 00", d); end
    wr_reg(2'd3, 8'hFF);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL race_no_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       h;
    int         n;
    wr_reg(2'd1, 8'h01);
    pulse(8'h01);
    wait_irq(n);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rmid_irq: got %b want 1 (waited %0d)", interrupt, n); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rmid_async_drop: got %b want 0", interrupt); end
    step(2);
    reset = 1'b1;
    step(6);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rmid_after_release: got %b want 0", interrupt); end
    rd_reg(2'd1, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rmid_mask: got %h want 00", d); end
    rd_reg(2'd0, d, h);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rmid_pending: got %h want 00", d); end
    wr_reg(2'd3, 8'hFF);
    wr_reg(2'd1, 8'h01);
    step(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got %b want 0", interrupt); end
    pulse(8'h01);
    wait_irq(n);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rmid_reprogrammed: got %b want 1 (waited %0d)", interrupt, n); end
    do_ack();
    rd_reg(2'd2, d, h);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL rmid_vector: got %h want 80", d); end
    wr_reg(2'd0, 8'h01);
    wr_reg(2'd3, 8'hFF);
  endtask

  initial begin
    reset         = 1'b0;
    irq_src       = 8'h00;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    out_port      = 8'h00;
    read_strobe   = 1'b0;
    interrupt_ack = 1'b0;
    test_reset();
    test_ack_idle();
    test_basic();
    test_priority();
    test_spurious();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
